// File: rtl/push_pop_unit.sv
// Stack push/pop sequencer: moves a register pair to/from memory one byte per
// state and updates SP once the second byte transfer completes.
package push_pop_pkg;
   typedef enum logic [2:0] {
      reg_A = 3'd0,
      reg_B = 3'd1,
      reg_C = 3'd2,
      reg_D = 3'd3,
      reg_E = 3'd4,
      reg_H = 3'd5,
      reg_L = 3'd6,
      reg_F = 3'd7
   } reg_sel_t;
endpackage

module push_pop_unit
   import push_pop_pkg::*;
#(
   parameter logic [15:0] SP_RESET = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [1:0]  pair,
   input  logic        sp_load,
   input  logic [15:0] sp_in,
   input  logic [7:0]  reg_outA,
   input  logic [3:0]  flags_in,
   output reg_sel_t    reg_sel,
   output logic [1:0]  load_en,
   output logic [7:0]  reg_input,
   output logic [15:0] addr_out,
   output logic [3:0]  flags_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] sp
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH_HI = 3'd1,
      PUSH_LO = 3'd2,
      POP_LO  = 3'd3,
      POP_HI  = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [1:0] PAIR_AF = 2'd3;

   state_t      state, state_nx;
   logic        op_q;
   logic [1:0]  pair_q;
   logic [7:0]  lo_q, hi_q;
   reg_sel_t    hi_reg, lo_reg;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // SP moves on the edge that completes the second byte, so it is already
   // updated while DONE is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp     <= SP_RESET;
         op_q   <= 1'b0;
         pair_q <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sp_load) begin
                  sp <= sp_in;
               end else if (start) begin
                  op_q   <= op;
                  pair_q <= pair;
               end
            end
            PUSH_LO: if (mem_ready) sp <= sp - 16'd2;
            POP_LO:  if (mem_ready) lo_q <= mem_rdata;
            POP_HI: begin
               if (mem_ready) begin
                  hi_q <= mem_rdata;
                  sp   <= sp + 16'd2;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start && !sp_load) state_nx = op ? POP_LO : PUSH_HI;
         PUSH_HI: if (mem_ready) state_nx = PUSH_LO;
         PUSH_LO: if (mem_ready) state_nx = DONE;
         POP_LO:  if (mem_ready) state_nx = POP_HI;
         POP_HI:  if (mem_ready) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      hi_reg = reg_A;
      lo_reg = reg_A;
      case (pair_q)
         2'd0: begin hi_reg = reg_B; lo_reg = reg_C; end
         2'd1: begin hi_reg = reg_D; lo_reg = reg_E; end
         2'd2: begin hi_reg = reg_H; lo_reg = reg_L; end
         default: begin hi_reg = reg_A; lo_reg = reg_A; end
      endcase
   end

   assign busy = (state != IDLE);

   always_comb begin
      reg_sel   = reg_A;
      load_en   = 2'b00;
      reg_input = '0;
      addr_out  = '0;
      flags_out = flags_in;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done      = 1'b0;
      case (state)
         PUSH_HI: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp - 16'd1;
            reg_sel   = hi_reg;
            mem_wdata = reg_outA;
         end
         PUSH_LO: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp - 16'd2;
            reg_sel   = lo_reg;
            mem_wdata = (pair_q == PAIR_AF) ? {flags_in, 4'b0000} : reg_outA;
         end
         POP_LO: begin
            mem_req  = 1'b1;
            mem_addr = sp;
         end
         POP_HI: begin
            mem_req  = 1'b1;
            mem_addr = sp + 16'd1;
         end
         DONE: begin
            done = 1'b1;
            if (op_q) begin
               if (pair_q == PAIR_AF) begin
                  load_en   = 2'b01;
                  reg_sel   = reg_A;
                  reg_input = hi_q;
                  flags_out = lo_q[7:4];
               end else begin
                  load_en  = 2'b10;
                  reg_sel  = hi_reg;
                  addr_out = {hi_q, lo_q};
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_push_pop_unit.sv
// Directed bench for push_pop_unit; acts as register file and memory by hand.
module tb_push_pop_unit;
   import push_pop_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, op, sp_load, mem_ready;
   logic [1:0]  pair;
   logic [15:0] sp_in;
   logic [7:0]  reg_outA, mem_rdata;
   logic [3:0]  flags_in;
   reg_sel_t    reg_sel;
   logic [1:0]  load_en;
   logic [7:0]  reg_input, mem_wdata;
   logic [15:0] addr_out, mem_addr, sp;
   logic [3:0]  flags_out;
   logic        mem_req, mem_we, busy, done;

   logic [7:0]  ra, rb, rc, rd, re, rh, rl;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   push_pop_unit #(.SP_RESET(16'hFFFE)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .pair(pair),
      .sp_load(sp_load), .sp_in(sp_in), .reg_outA(reg_outA), .flags_in(flags_in),
      .reg_sel(reg_sel), .load_en(load_en), .reg_input(reg_input), .addr_out(addr_out),
      .flags_out(flags_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .done(done), .sp(sp)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (reg_sel)
         reg_B:   reg_outA = rb;
         reg_C:   reg_outA = rc;
         reg_D:   reg_outA = rd;
         reg_E:   reg_outA = re;
         reg_H:   reg_outA = rh;
         reg_L:   reg_outA = rl;
         default: reg_outA = ra;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"}, busy, 1'b0);
      chk({tag, ".done"}, done, 1'b0);
      chk({tag, ".mem_req"}, mem_req, 1'b0);
      chk({tag, ".mem_we"}, mem_we, 1'b0);
      chk({tag, ".load_en"}, load_en, 2'b00);
      chk({tag, ".flags_out"}, flags_out, flags_in);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; pair = 2'd0; sp_load = 1'b0;
      sp_in = 16'h0000; mem_ready = 1'b1; mem_rdata = 8'h00; flags_in = 4'h5;
      ra = 8'h00; rb = 8'h12; rc = 8'h34; rd = 8'h00; re = 8'h00; rh = 8'hAB; rl = 8'hCD;

      // reset: start and sp_load are overridden
      start = 1'b1; sp_load = 1'b1; sp_in = 16'h1111;
      step();
      chk_idle("rst");
      chk("rst.sp", sp, 16'hFFFE);
      start = 1'b0; sp_load = 1'b0; rst = 1'b0;
      step();
      chk_idle("post_rst");
      chk("post_rst.sp", sp, 16'hFFFE);

      // PUSH BC
      start = 1'b1; op = 1'b0; pair = 2'd0;
      step(); start = 1'b0;
      chk("pbc.hi.busy", busy, 1'b1);
      chk("pbc.hi.req", {mem_req, mem_we}, 2'b11);
      chk("pbc.hi.addr", mem_addr, 16'hFFFD);
      chk("pbc.hi.sel", reg_sel, reg_B);
      chk("pbc.hi.wdata", mem_wdata, 8'h12);
      chk("pbc.hi.done", done, 1'b0);
      step();
      chk("pbc.lo.addr", mem_addr, 16'hFFFC);
      chk("pbc.lo.sel", reg_sel, reg_C);
      chk("pbc.lo.wdata", mem_wdata, 8'h34);
      chk("pbc.lo.done", done, 1'b0);
      step();
      chk("pbc.done", done, 1'b1);
      chk("pbc.done.req", mem_req, 1'b0);
      chk("pbc.done.load_en", load_en, 2'b00);
      chk("pbc.sp", sp, 16'hFFFC);
      step();
      chk("pbc.after.done", done, 1'b0);
      chk("pbc.after.busy", busy, 1'b0);

      // POP DE
      start = 1'b1; op = 1'b1; pair = 2'd1;
      step(); start = 1'b0;
      chk("pde.lo.req", {mem_req, mem_we}, 2'b10);
      chk("pde.lo.addr", mem_addr, 16'hFFFC);
      mem_rdata = 8'h34;
      step();
      chk("pde.hi.req", {mem_req, mem_we}, 2'b10);
      chk("pde.hi.addr", mem_addr, 16'hFFFD);
      chk("pde.hi.load_en", load_en, 2'b00);
      mem_rdata = 8'h12;
      step();
      chk("pde.done", done, 1'b1);
      chk("pde.load_en", load_en, 2'b10);
      chk("pde.sel", reg_sel, reg_D);
      chk("pde.addr_out", addr_out, 16'h1234);
      chk("pde.sp", sp, 16'hFFFE);
      step();

      // POP AF; SP wraps FFFE+2 -> 0000
      start = 1'b1; op = 1'b1; pair = 2'd3;
      step(); start = 1'b0;
      chk("paf.lo.addr", mem_addr, 16'hFFFE);
      mem_rdata = 8'hB7;
      step();
      chk("paf.hi.addr", mem_addr, 16'hFFFF);
      mem_rdata = 8'h5A;
      step();
      chk("paf.load_en", load_en, 2'b01);
      chk("paf.sel", reg_sel, reg_A);
      chk("paf.reg_input", reg_input, 8'h5A);
      chk("paf.flags_out", flags_out, 4'hB);
      chk("paf.sp", sp, 16'h0000);
      step();
      chk("paf.after.flags_out", flags_out, 4'h5);
      chk("paf.after.load_en", load_en, 2'b00);

      // sp_load wins over a simultaneous start
      sp_load = 1'b1; sp_in = 16'hFF00; start = 1'b1; op = 1'b0; pair = 2'd2;
      step(); sp_load = 1'b0; start = 1'b0;
      chk("spl.sp", sp, 16'hFF00);
      chk("spl.busy", busy, 1'b0);

      // PUSH HL with three wait cycles; start/sp_load while busy ignored
      mem_ready = 1'b0;
      start = 1'b1; op = 1'b0; pair = 2'd2;
      step();
      chk("phl.w0.addr", mem_addr, 16'hFEFF);
      chk("phl.w0.wdata", mem_wdata, 8'hAB);
      op = 1'b1; pair = 2'd0; sp_load = 1'b1; sp_in = 16'h1234;
      step(); start = 1'b0; sp_load = 1'b0;
      chk("phl.w1.addr", mem_addr, 16'hFEFF);
      chk("phl.w1.wdata", mem_wdata, 8'hAB);
      chk("phl.w1.sel", reg_sel, reg_H);
      step();
      chk("phl.w2.addr", mem_addr, 16'hFEFF);
      chk("phl.w2.req", {mem_req, mem_we}, 2'b11);
      step();
      chk("phl.w3.addr", mem_addr, 16'hFEFF);
      chk("phl.w3.sp", sp, 16'hFF00);
      mem_ready = 1'b1;
      step();
      chk("phl.lo.addr", mem_addr, 16'hFEFE);
      chk("phl.lo.wdata", mem_wdata, 8'hCD);
      chk("phl.lo.done", done, 1'b0);
      step();
      chk("phl.done", done, 1'b1);
      chk("phl.sp", sp, 16'hFEFE);
      step();
      chk("phl.after.busy", busy, 1'b0);
      chk("phl.after.sp", sp, 16'hFEFE);

      // PUSH AF from sp=0000: addresses wrap to FFFF/FFFE
      sp_load = 1'b1; sp_in = 16'h0000;
      step(); sp_load = 1'b0;
      ra = 8'h77; flags_in = 4'hA;
      start = 1'b1; op = 1'b0; pair = 2'd3;
      step(); start = 1'b0;
      chk("paf_push.hi.addr", mem_addr, 16'hFFFF);
      chk("paf_push.hi.wdata", mem_wdata, 8'h77);
      step();
      chk("paf_push.lo.addr", mem_addr, 16'hFFFE);
      chk("paf_push.lo.wdata", mem_wdata, 8'hA0);
      step();
      chk("paf_push.done", done, 1'b1);
      chk("paf_push.sp", sp, 16'hFFFE);
      chk("paf_push.flags_out", flags_out, 4'hA);
      step();

      // POP BC from sp=FFFF: FFFF, 0000, sp -> 0001
      sp_load = 1'b1; sp_in = 16'hFFFF;
      step(); sp_load = 1'b0;
      start = 1'b1; op = 1'b1; pair = 2'd0;
      step(); start = 1'b0;
      chk("pbc_wrap.lo.addr", mem_addr, 16'hFFFF);
      mem_rdata = 8'h11;
      step();
      chk("pbc_wrap.hi.addr", mem_addr, 16'h0000);
      mem_rdata = 8'h22;
      step();
      chk("pbc_wrap.sp", sp, 16'h0001);
      chk("pbc_wrap.addr_out", addr_out, 16'h2211);
      chk("pbc_wrap.sel", reg_sel, reg_B);
      step();

      // reset during POP_HI aborts without writeback
      start = 1'b1; op = 1'b1; pair = 2'd1;
      step(); start = 1'b0;
      mem_rdata = 8'h99;
      step();
      chk("abort.in_pop_hi.addr", mem_addr, 16'h0002);
      rst = 1'b1;
      step();
      chk_idle("abort");
      chk("abort.sp", sp, 16'hFFFE);
      rst = 1'b0;
      step();
      chk_idle("abort.after");
      chk("abort.after.sp", sp, 16'hFFFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
